l2_cache: RTL and testbench

L2_CACHE -- requirements
Module: l2_cache

---
 rtl/l2_cache_pkg.sv | 28 ++
 rtl/l2_cache_if.sv | 34 +++
 rtl/l2_way_array.sv | 43 ++++
 rtl/l2_cache.sv | 194 +++++++++++++++++++
 tb/tb_l2_cache.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and geometry for the 2-way write-back L2 cache.
// Imported by the cache interface, the way array and the top level.
package l2_cache_pkg;

    localparam int unsigned SETS   = 32;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned TAG_W  = 23;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned ADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate,
        StRespond,
        StSettle
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } way_entry_t;

endpackage

// File: rtl/l2_cache_if.sv
// L1-facing request bus and memory-facing line bus of the L2 cache.
// The slave modport is the cache side; master is the L1 + memory side.
interface l2_cache_if;
    import l2_cache_pkg::*;

    logic              l1_read;
    logic              l1_write;
    logic [ADDR_W-1:0] l1_addr;
    logic [LINE_W-1:0] l1_wdata;
    logic [LINE_W-1:0] l1_rdata;
    logic              l1_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  l1_read, l1_write, l1_addr, l1_wdata,
        output l1_rdata, l1_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output l1_read, l1_write, l1_addr, l1_wdata,
        input  l1_rdata, l1_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/l2_way_array.sv
// Storage for one cache way: valid/dirty flags (reset), tag and data (no reset).
// Asynchronous read at idx_i, synchronous write of a whole entry at idx_i.
module l2_way_array
    import l2_cache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    output way_entry_t       entry_o,
    input  logic             we_i,
    input  way_entry_t       entry_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= entry_i.valid;
            dirty_q[idx_i] <= entry_i.dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i && !rst_i) begin
            tag_q[idx_i]  <= entry_i.tag;
            data_q[idx_i] <= entry_i.data;
        end
    end

    always_comb begin
        entry_o.valid = valid_q[idx_i];
        entry_o.dirty = dirty_q[idx_i];
        entry_o.tag   = tag_q[idx_i];
        entry_o.data  = data_q[idx_i];
    end

endmodule

// File: rtl/l2_cache.sv
// 2-way set-associative write-back L2 cache, 32 sets of 128-bit lines, per-set LRU bit.
// Define L2_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
module l2_cache
    import l2_cache_pkg::*;
(
    input  logic        clk,
    input  logic        proc_reset,
    l2_cache_if.slave   bus,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              is_write_q, is_write_d;
    logic              way_q, way_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    way_entry_t        entry [WAYS];
    way_entry_t        wr_entry;
    logic [WAYS-1:0]   way_we;
    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic              hit_way;
    logic              victim;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic              l1_ready;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l2_way_array u_way (
            .clk_i   (clk),
            .rst_i   (proc_reset),
            .idx_i   (idx),
            .entry_o (entry[w]),
            .we_i    (way_we[w]),
            .entry_i (wr_entry)
        );
        assign hit_vec[w] = entry[w].valid && (entry[w].tag == tag);
    end

    assign hit     = |hit_vec;
    assign hit_way = ~hit_vec[0];
    // Fill empty ways in order before falling back to the LRU way.
    assign victim  = !entry[0].valid ? 1'b0 :
                     !entry[1].valid ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        is_write_d     = is_write_q;
        way_d          = way_q;
        lru_d          = lru_q;
        way_we         = '0;
        wr_entry.valid = 1'b1;
        wr_entry.dirty = 1'b1;
        wr_entry.tag   = tag;
        wr_entry.data  = wdata_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = addr_q;
        l1_ready       = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.l1_read || bus.l1_write) begin
                    addr_d     = bus.l1_addr;
                    wdata_d    = bus.l1_wdata;
                    is_write_d = bus.l1_write;
                    state_d    = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    way_d = hit_way;
                    if (is_write_q) begin
                        way_we[hit_way] = 1'b1;
                    end else begin
                        rdata_d = entry[hit_way].data;
                    end
                    state_d = StRespond;
                end else begin
                    way_d = victim;
                    if (entry[victim].valid && entry[victim].dirty) begin
                        state_d = StWriteback;
                    end else if (is_write_q) begin
                        way_we[victim] = 1'b1;
                        state_d        = StRespond;
                    end else begin
                        state_d = StAllocate;
                    end
                end
            end
            StWriteback: begin
                mem_write = 1'b1;
                mem_addr  = {entry[way_q].tag, idx};
                if (bus.mem_ready) begin
                    if (is_write_q) begin
                        way_we[way_q] = 1'b1;
                        state_d       = StRespond;
                    end else begin
                        state_d = StAllocate;
                    end
                end
            end
            StAllocate: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    wr_entry.dirty = 1'b0;
                    wr_entry.data  = bus.mem_rdata;
                    way_we[way_q]  = 1'b1;
                    rdata_d        = bus.mem_rdata;
                    state_d        = StRespond;
                end
            end
            StRespond: begin
                l1_ready   = 1'b1;
                lru_d[idx] = ~way_q;
                state_d    = StSettle;
            end
            // L1 sees ready a cycle late, so its still-held request is ignored here.
            StSettle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            way_q      <= 1'b0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            way_q      <= way_d;
            lru_q      <= lru_d;
        end
    end

    assign bus.l1_rdata  = rdata_q;
    assign bus.l1_ready  = l1_ready;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = entry[way_q].data;

`ifdef L2_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == StCompare) begin
            if (hit && (hits_q != 16'hFFFF)) begin
                hits_q <= hits_q + 16'd1;
            end
            if (!hit && (misses_q != 16'hFFFF)) begin
                misses_q <= misses_q + 16'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Self-checking bench for l2_cache: directed scenarios plus random traffic against a
// recency-ordered per-set line model and a flat backing-memory model.
module tb_l2_cache;
    import l2_cache_pkg::*;

    logic        clk = 1'b0;
    logic        proc_reset;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;

    l2_cache_if bus ();

    l2_cache dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .bus         (bus),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder state
    logic [127:0] back [logic [27:0]];
    logic [28:0]  ev_q [$];
    logic [127:0] wb_data;
    bit           stall    = 1'b0;
    int           overlap  = 0;
    int           drop_err = 0;

    // Reference model: per set, resident lines ordered most-recent first
    typedef struct {
        logic [22:0]  tag;
        bit           dirty;
        logic [127:0] data;
    } mline_t;

    mline_t       mset [32][2];
    int           mcnt [32];
    logic [127:0] exp_mem [logic [27:0]];
    int           m_hits;
    int           m_misses;
    logic [127:0] exp_rdata;

    function automatic logic [127:0] init_line(input logic [27:0] a);
        return {4{4'hC, a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    initial begin
        int  wait_cnt;
        int  mem_lat;
        bit  prev_wr;
        wait_cnt       = 0;
        mem_lat        = 1;
        prev_wr        = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                wait_cnt      = 0;
                if (prev_wr ? bus.mem_write : bus.mem_read) drop_err++;
            end else if ((bus.mem_read || bus.mem_write) && !proc_reset) begin
                wait_cnt++;
                if (!stall && wait_cnt >= mem_lat) begin
                    if (bus.mem_write) begin
                        back[bus.mem_addr] = bus.mem_wdata;
                        wb_data            = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = back.exists(bus.mem_addr) ? back[bus.mem_addr]
                                                                  : init_line(bus.mem_addr);
                    end
                    ev_q.push_back({bus.mem_write, bus.mem_addr});
                    prev_wr       = bus.mem_write;
                    bus.mem_ready = 1'b1;
                    mem_lat       = $urandom_range(1, 4);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_read && bus.mem_write) overlap++;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 32; s++) mcnt[s] = 0;
        m_hits    = 0;
        m_misses  = 0;
        exp_rdata = '0;
    endtask

    task automatic run_req(input bit wr, input bit both, input logic [27:0] a,
                           input logic [127:0] d);
        int           s;
        int           h;
        int           lat;
        int           pulses;
        logic [22:0]  t;
        mline_t       ln;
        logic [28:0]  exp_ev [$];
        logic [127:0] exp_wb;
        bit           exp_wb_v;

        s        = int'(a[4:0]);
        t        = a[27:5];
        h        = -1;
        exp_wb   = '0;
        exp_wb_v = 1'b0;
        for (int i = 0; i < mcnt[s]; i++) if (mset[s][i].tag == t) h = i;
        if (h >= 0) begin
            m_hits++;
            ln = mset[s][h];
            if (h == 1) mset[s][1] = mset[s][0];
        end else begin
            m_misses++;
            if (mcnt[s] == 2) begin
                if (mset[s][1].dirty) begin
                    exp_ev.push_back({1'b1, mset[s][1].tag, a[4:0]});
                    exp_wb   = mset[s][1].data;
                    exp_wb_v = 1'b1;
                    exp_mem[{mset[s][1].tag, a[4:0]}] = mset[s][1].data;
                end
                mcnt[s] = 1;
            end
            if (mcnt[s] == 1) mset[s][1] = mset[s][0];
            mcnt[s]++;
            ln.tag   = t;
            ln.dirty = 1'b0;
            ln.data  = '0;
            if (!wr) begin
                exp_ev.push_back({1'b0, a});
                ln.data = exp_mem.exists(a) ? exp_mem[a] : init_line(a);
            end
        end
        if (wr) begin
            ln.dirty = 1'b1;
            ln.data  = d;
        end else begin
            exp_rdata = ln.data;
        end
        mset[s][0] = ln;

        ev_q.delete();
        @(negedge clk);
        bus.l1_read  = !wr || both;
        bus.l1_write = wr;
        bus.l1_addr  = a;
        bus.l1_wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.l1_ready && lat < 200);
        chk("ready_seen", 128'(bus.l1_ready), 128'(1));
        pulses = bus.l1_ready ? 1 : 0;
        // Keep the request up through the settle cycle, as a late-sampling L1 would.
        repeat (2) begin
            @(negedge clk);
            if (bus.l1_ready) pulses++;
        end
        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        @(negedge clk);
        if (bus.l1_ready) pulses++;

        chk("ready_pulses", 128'(pulses), 128'(1));
        chk("l1_rdata", bus.l1_rdata, exp_rdata);
        chk("mem_ev_count", 128'(ev_q.size()), 128'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
            chk("mem_ev", 128'(ev_q[i]), 128'(exp_ev[i]));
        end
        if (exp_wb_v) chk("wb_data", wb_data, exp_wb);
        if (h >= 0) chk("hit_latency", 128'(lat), 128'(2));
    endtask

    initial begin
        logic [27:0]  a;
        logic [127:0] d;
        bit           wr;
        int           n;
        int           pulses;

        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        bus.l1_addr  = '0;
        bus.l1_wdata = '0;
        proc_reset   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_l1_ready", 128'(bus.l1_ready), 128'(0));
        chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
        chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
        chk("rst_l1_rdata", bus.l1_rdata, 128'(0));
        chk("rst_stat_hits", 128'(stat_hits), 128'(0));
        chk("rst_stat_misses", 128'(stat_misses), 128'(0));
        proc_reset = 1'b0;

        // Read miss then re-read hit
        run_req(1'b0, 1'b0, 28'h0000020, '0);
        run_req(1'b0, 1'b0, 28'h0000020, '0);

        // Write miss allocates without a memory read; read back hits
        d = {$urandom, $urandom, $urandom, $urandom};
        run_req(1'b1, 1'b0, 28'h0000041, d);
        run_req(1'b0, 1'b0, 28'h0000041, '0);

        // LRU victim selection in set 3
        run_req(1'b0, 1'b0, 28'h0000003, '0);
        run_req(1'b0, 1'b0, 28'h0000023, '0);
        run_req(1'b0, 1'b0, 28'h0000003, '0);
        run_req(1'b0, 1'b0, 28'h0000043, '0);
        run_req(1'b0, 1'b0, 28'h0000003, '0);
        run_req(1'b0, 1'b0, 28'h0000023, '0);

        // Dirty eviction in set 5, write and read both high
        d = {$urandom, $urandom, $urandom, $urandom};
        run_req(1'b1, 1'b1, 28'h0000005, d);
        d = {$urandom, $urandom, $urandom, $urandom};
        run_req(1'b1, 1'b0, 28'h0000025, d);
        run_req(1'b0, 1'b0, 28'h0000045, '0);
        run_req(1'b0, 1'b0, 28'h0000005, '0);

        for (int i = 0; i < 60; i++) begin
            a  = {23'($urandom_range(0, 3)), 5'($urandom_range(8, 11))};
            d  = {$urandom, $urandom, $urandom, $urandom};
            wr = 1'($urandom_range(0, 1));
            run_req(wr, 1'($urandom_range(0, 1)), a, d);
        end

        // Reset during ALLOCATE abandons the transaction
        stall  = 1'b1;
        pulses = 0;
        @(negedge clk);
        bus.l1_read = 1'b1;
        bus.l1_addr = 28'h00003E7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.l1_ready) pulses++;
        end while (!bus.mem_read && n < 50);
        chk("alloc_reached", 128'(bus.mem_read), 128'(1));
        proc_reset  = 1'b1;
        bus.l1_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        chk("rst_mid_mem_read", 128'(bus.mem_read), 128'(0));
        repeat (4) begin
            if (bus.l1_ready) pulses++;
            @(negedge clk);
        end
        chk("rst_mid_no_ready", 128'(pulses), 128'(0));
        stall = 1'b0;
        model_reset();

        run_req(1'b0, 1'b0, 28'h00003E7, '0);
        run_req(1'b0, 1'b0, 28'h00003E7, '0);
        run_req(1'b0, 1'b0, 28'h00003C7, '0);
        run_req(1'b0, 1'b0, 28'h00003E7, '0);
        run_req(1'b0, 1'b0, 28'h00003C7, '0);
`ifdef L2_STATS_EN
        chk("stat_hits", 128'(stat_hits), 128'(m_hits));
        chk("stat_misses", 128'(stat_misses), 128'(m_misses));
`else
        chk("stat_hits", 128'(stat_hits), 128'(0));
        chk("stat_misses", 128'(stat_misses), 128'(0));
`endif

        chk("mem_rw_overlap", 128'(overlap), 128'(0));
        chk("mem_req_drop", 128'(drop_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
